// File: rtl/pc_seq_if.sv
// pc_seq_if: fetch-control bundle between pc_sequencer and its execute/imem/Mux_Sel_Dir neighbours
interface pc_seq_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             branch_req;
  logic [WIDTH-1:0] branch_target;
  logic             imem_ready;
  logic             imem_req;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] direction;
  logic             sel_dir;
  logic             fetch_valid;
  logic             misalign_err;
  modport master (
    input  stall, branch_req, branch_target, imem_ready,
    output imem_req, pc, direction, sel_dir, fetch_valid, misalign_err
  );
  modport slave (
    output stall, branch_req, branch_target, imem_ready,
    input  imem_req, pc, direction, sel_dir, fetch_valid, misalign_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner and fetch sequencer; define PC_SEQ_ALIGN_CHECK_EN to reject misaligned branch targets
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               PC_STEP      = 4
) (
  input logic     clk,
  input logic     reset,
  pc_seq_if.master bus
);
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_REDIRECT} state_t;
  state_t           state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] dir_q;
  logic             active;
  logic             bad;
  logic             take;
  logic             fire;
  assign active = state != S_BOOT;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic err_q;
  assign bad = active && bus.branch_req && |bus.branch_target[1:0];
  assign bus.misalign_err = err_q;
  // sticky flag for any rejected misaligned redirect
  always_ff @(posedge clk)
    err_q <= reset ? 1'b0 : err_q | bad;
`else
  assign bad = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif
  assign take = !reset && active && bus.branch_req && !bad;
  assign fire = !reset && state == S_FETCH && !bus.branch_req && !bus.stall && bus.imem_ready;
  assign bus.imem_req    = !reset && state == S_FETCH;
  assign bus.pc          = pc_q;
  assign bus.sel_dir     = take;
  assign bus.direction   = take ? bus.branch_target : dir_q;
  assign bus.fetch_valid = fire;
  // every non-branch cycle (boot, bubble or fetch) lands in S_FETCH; a redirect always costs one bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
      pc_q  <= RESET_VECTOR;
      dir_q <= '0;
    end else begin
      state <= take ? S_REDIRECT : S_FETCH;
      if (take) begin
        pc_q  <= bus.branch_target;
        dir_q <= bus.branch_target;
      end else if (fire)
        pc_q <= pc_q + WIDTH'(PC_STEP);
    end
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-address controller for the Proyecto4 datapath.
- Owns the program-counter register and sequences fetches to instruction memory.
- Drives the select and jump-address inputs of the downstream Mux_Sel_Dir: sel_dir chooses between sequential PC and branch target (direction).
- Handles reset vector, stalls, branch redirects with in-flight fetch discard, and memory wait states.

Parameters:
- WIDTH, 32, address width of pc/direction/branch_target.
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, sequential increment added to pc per accepted fetch.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; no new fetch accepted while high.
- branch_req  input  1  one-cycle redirect request from execute stage.
- branch_target  input  WIDTH  redirect address, sampled when branch_req=1.
- imem_ready  input  1  instruction memory has data for current pc this cycle.
- imem_req  output  1  fetch request for address pc.
- pc  output  WIDTH  registered current fetch address.
- direction  output  WIDTH  jump address presented to Mux_Sel_Dir.
- sel_dir  output  1  1 = mux selects direction, 0 = sequential pc path.
- fetch_valid  output  1  pulse: instruction at pc accepted this cycle.
- misalign_err  output  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (reset=1 at a clk edge, any state, mid-fetch included):
  - pc=RESET_VECTOR, state=S_BOOT.
  - imem_req=0, fetch_valid=0, sel_dir=0, direction=0, misalign_err=0.
  - A pending branch is discarded.
- States:
  - S_BOOT: imem_req=0 for one cycle, then go to S_FETCH.
  - S_FETCH: imem_req=1, awaiting imem_ready.
  - S_REDIRECT: one bubble cycle after a branch; imem_req=0, then go to S_FETCH.
- S_FETCH per cycle, in priority order:
  1. branch_req=1 (wins over stall and imem_ready):
     - pc<=branch_target, sel_dir=1, direction=branch_target, fetch_valid=0.
     - A coincident imem_ready is dropped (flush).
     - Next state S_REDIRECT.
  2. stall=1: pc holds, fetch_valid=0, imem_req stays 1, sel_dir=0.
  3. imem_ready=1: fetch_valid=1, pc<=pc+PC_STEP, sel_dir=0.
  4. Otherwise: pc holds, wait state.
- Branch handling outside S_FETCH:
  - branch_req in S_REDIRECT: accepted the same way (pc<=target, sel_dir=1), stay in S_REDIRECT.
  - branch_req in S_BOOT: ignored.
- sel_dir/direction are combinational for the cycle the PC loads a target. Otherwise sel_dir=0 and direction holds its last value.
- Arithmetic: pc+PC_STEP is modulo 2^WIDTH; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Latency:
  - First imem_req: 1 cycle after reset deasserts.
  - First fetch_valid at the earliest in the 2nd cycle after reset release.
  - Branch to first fetch_valid at target: minimum 2 cycles (redirect + fetch).
- fetch_valid never asserts while imem_req=0 or during reset.

Optional Feature:
- Macro: PC_SEQ_ALIGN_CHECK_EN.
- Defined:
  - A branch_target with nonzero bits [1:0] is rejected: pc unchanged, sel_dir=0, state stays S_FETCH.
  - misalign_err sets and remains 1 until reset.
- Undefined:
  - Any target is loaded as-is.
  - misalign_err is tied 0.

Test Plan:
- Reset release, imem_ready=1 continuously -> imem_req rises 1 cycle later; pc sequence 0,4,8,C with fetch_valid each cycle; sel_dir=0 throughout.
- Fetch at pc=8, stall=1 for 3 cycles with imem_ready=1 -> pc stays 8, fetch_valid=0 for 3 cycles; resumes 8->C after stall drops.
- pc=C, branch_req=1, branch_target=32'h00000100, imem_ready=1 same cycle:
  - sel_dir=1 and direction=100 that cycle, fetch_valid=0.
  - Next cycle imem_req=0.
  - Then fetch at 100, next 104.
- Branch to 32'hFFFFFFFC, imem_ready=1 -> fetches FFFFFFFC then pc wraps to 0, fetch_valid=1 both times.
- Reset asserted in S_REDIRECT after branch to 200 -> next cycle pc=0, imem_req=0, sel_dir=0; fetch restarts at 0, not 200.
- With PC_SEQ_ALIGN_CHECK_EN, branch_target=32'h00000102:
  - pc holds, sel_dir=0, misalign_err=1 and stays 1.
  - Without the macro: pc=102, misalign_err=0.
